// File: rtl/ff_load_sequencer.sv
// Parallel-to-serial loader for a downstream enable flop: one bit per ENABLE cycle, GAP idle cycles between bits.
// Define FF_LOAD_SEQ_READBACK_EN to compare Q against each written bit and flag mismatches on ERR.
module ff_load_sequencer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             D,
  output logic             ENABLE,
  input  logic             Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             cur_bit;
  logic             accept;
  logic             last;
  logic             gap_done;

  assign cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign accept  = IN_VALID && (state == S_IDLE);
  assign last    = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SEND;
      S_SEND: begin
        if (last)         state_nxt = S_FIN;
        else if (GAP > 0) state_nxt = S_GAP;
        else              state_nxt = S_SEND;
      end
      S_GAP:  if (gap_done) state_nxt = S_SEND;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY = 1'b0;
    D        = 1'b0;
    ENABLE   = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      S_IDLE: IN_READY = 1'b1;
      S_SEND: begin
        ENABLE = 1'b1;
        D      = cur_bit;
        BUSY   = 1'b1;
      end
      S_GAP: begin
        D    = last_bit;
        BUSY = 1'b1;
      end
      S_FIN:  DONE = 1'b1;
      default: ;
    endcase
  end

  // The shift register advances at the end of SEND, so GAP drives D from a copy of the sent bit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (accept) begin
      shreg   <= IN_DATA;
      bit_cnt <= '0;
    end else if (state == S_SEND) begin
      last_bit <= cur_bit;
      if (!last) begin
        bit_cnt <= bit_cnt + CW'(1);
        shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      localparam int GW = $clog2(GAP + 1);
      logic [GW-1:0] gap_cnt;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)            gap_cnt <= '0;
        else if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
        else                     gap_cnt <= '0;
      end

      assign gap_done = (gap_cnt == GW'(GAP - 1));
    end else begin : g_nogap
      assign gap_done = 1'b1;
    end
  endgenerate

`ifdef FF_LOAD_SEQ_READBACK_EN
  logic chk_pending;
  logic chk_bit;
  logic err_q;

  // Q reflects a SEND bit one edge later, so each check lands one cycle after its SEND.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chk_pending <= 1'b0;
      chk_bit     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      chk_pending <= (state == S_SEND);
      chk_bit     <= cur_bit;
      if (accept)                           err_q <= 1'b0;
      else if (chk_pending && Q != chk_bit) err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  // Readback absent: Q is deliberately ignored and ERR is constant 0.
  assign ERR = Q & 1'b0;
`endif

endmodule

// File: tb/tb_ff_load_sequencer.sv
// Self-checking bench: two sequencer configurations, each feeding a behavioural enable flop.
// Expected waveforms are built per word from the bit order, gap length and readback rules.
module tb_ff_load_sequencer;

`ifdef FF_LOAD_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld;
  logic [7:0] data [2];
  logic [1:0] force_q;
  logic [1:0] fq;
  wire  [1:0] rdy, d, en, busy, done, err, q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign q = fq & ~force_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fq <= '0;
    else for (int i = 0; i < 2; i++) if (en[i]) fq[i] <= d[i];
  end

  ff_load_sequencer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u0 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(vld[0]), .IN_READY(rdy[0]), .IN_DATA(data[0]),
    .D(d[0]), .ENABLE(en[0]), .Q(q[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]));

  ff_load_sequencer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0)) u1 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(vld[1]), .IN_READY(rdy[1]), .IN_DATA(data[1]),
    .D(d[1]), .ENABLE(en[1]), .Q(q[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer word w to instance i, then check every cycle of the transfer and the following IDLE cycle.
  task automatic run(input int i, input logic [7:0] w, input bit hold, input logic [7:0] nxt);
    int gap = (i == 0) ? 0 : 2;
    bit msb = (i == 0);
    bit en_e[$], d_e[$], busy_e[$], done_e[$];
    int first_bad = -1;
    int n;
    bit b;
    bit err_e;
    for (int k = 0; k < 8; k++) begin
      b = msb ? w[7-k] : w[k];
      en_e.push_back(1'b1); d_e.push_back(b); busy_e.push_back(1'b1); done_e.push_back(1'b0);
      if (first_bad < 0 && force_q[i] && b) first_bad = en_e.size();
      if (k < 7) repeat (gap) begin
        en_e.push_back(1'b0); d_e.push_back(b); busy_e.push_back(1'b1); done_e.push_back(1'b0);
      end
    end
    en_e.push_back(1'b0); d_e.push_back(1'b0); busy_e.push_back(1'b0); done_e.push_back(1'b1);
    n = en_e.size();

    chk("ready_before_accept", rdy[i], 1'b1);
    vld[i]  = 1'b1;
    data[i] = w;
    @(negedge clk);
    for (int t = 1; t <= n; t++) begin
      err_e = RB && first_bad > 0 && t >= first_bad + 2;
      chk("enable", en[i], en_e[t-1]);
      chk("d", d[i], d_e[t-1]);
      chk("busy", busy[i], busy_e[t-1]);
      chk("done", done[i], done_e[t-1]);
      chk("ready_busy", rdy[i], 1'b0);
      chk("err", err[i], err_e);
      if (t < n) begin
        vld[i]  = 1'($urandom);
        data[i] = 8'($urandom);
      end else begin
        vld[i]  = hold;
        data[i] = hold ? nxt : 8'($urandom);
      end
      @(negedge clk);
    end
    err_e = RB && first_bad > 0 && n + 1 >= first_bad + 2;
    chk("ready_after_fin", rdy[i], 1'b1);
    chk("enable_idle", en[i], 1'b0);
    chk("busy_idle", busy[i], 1'b0);
    chk("done_idle", done[i], 1'b0);
    chk("err_idle", err[i], err_e);
    chk("flop_q_last_bit", fq[i], msb ? w[0] : w[7]);
  endtask

  initial begin
    logic [7:0] w;
    rst_n   = 1'b0;
    vld     = '0;
    force_q = '0;
    data[0] = '0;
    data[1] = '0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", rdy[i], 1'b1);
      chk("reset_d", d[i], 1'b0);
      chk("reset_enable", en[i], 1'b0);
      chk("reset_busy", busy[i], 1'b0);
      chk("reset_done", done[i], 1'b0);
      chk("reset_err", err[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 8'hA5, 1'b0, 8'h00);
    run(1, 8'h81, 1'b0, 8'h00);

    run(0, 8'h3C, 1'b1, 8'hC3);
    run(0, 8'hC3, 1'b0, 8'h00);

    repeat (3) run(0, 8'($urandom), 1'b0, 8'h00);
    repeat (3) run(1, 8'($urandom), 1'b0, 8'h00);

    force_q[0] = 1'b1;
    run(0, 8'hFF, 1'b0, 8'h00);
    force_q[0] = 1'b0;
    run(0, 8'hFF, 1'b0, 8'h00);
    run(0, 8'($urandom), 1'b0, 8'h00);

    // Reset asserted between edges during the fourth SEND cycle; bit 3 sent is a 1.
    w = 8'($urandom) | 8'h10;
    chk("ready_before_reset_word", rdy[0], 1'b1);
    vld[0]  = 1'b1;
    data[0] = w;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("enable_send4", en[0], 1'b1);
    chk("d_send4", d[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_enable", en[0], 1'b0);
    chk("async_reset_d", d[0], 1'b0);
    chk("async_reset_busy", busy[0], 1'b0);
    chk("async_reset_ready", rdy[0], 1'b1);
    chk("async_reset_done", done[0], 1'b0);
    chk("async_reset_err", err[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", done[0], 1'b0);
      chk("idle_after_reset", rdy[0], 1'b1);
    end

    run(0, 8'($urandom), 1'b0, 8'h00);
    run(1, 8'($urandom), 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
